// File: rtl/ddr3_emu_pkg.sv
// ddr3_emu_pkg: shared types, command priority and lane helpers for the DDR3 emulation responder.
package ddr3_emu_pkg;

    localparam int BURST_WORDS = 8;
    localparam int WORD_W      = 16;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_READ, S_REFRESH} state_e;
    typedef enum logic [1:0] {CMD_NONE, CMD_RD, CMD_WR, CMD_REF} cmd_e;

    function automatic cmd_e pick_cmd(input logic rd, input logic wr, input logic refresh);
        return refresh ? CMD_REF : wr ? CMD_WR : rd ? CMD_RD : CMD_NONE;
    endfunction

    function automatic logic multi_cmd(input logic rd, input logic wr, input logic refresh);
        return (rd & wr) | (rd & refresh) | (wr & refresh);
    endfunction

    function automatic logic [6:0] lane_lsb(input logic [2:0] lane);
        return {lane, 4'b0000};
    endfunction

endpackage

// File: rtl/ddr3_emu_responder_if.sv
// ddr3_emu_responder_if: ddr3_controller user-port bundle with master (test FSM) and slave (responder) views.
interface ddr3_emu_responder_if #(
    parameter int ADDR_WIDTH = 26
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd;
    logic                  wr;
    logic                  refresh;
    logic [15:0]           din;
    logic [15:0]           dout;
    logic [127:0]          dout128;
    logic                  data_ready;
    logic                  busy;
    logic                  write_level_done;
    logic                  read_calib_done;
    logic                  cmd_error;
    logic                  refresh_miss;

    modport master (
        output addr, rd, wr, refresh, din,
        input  dout, dout128, data_ready, busy, write_level_done, read_calib_done, cmd_error, refresh_miss
    );

    modport slave (
        input  addr, rd, wr, refresh, din,
        output dout, dout128, data_ready, busy, write_level_done, read_calib_done, cmd_error, refresh_miss
    );
endinterface

// File: rtl/ddr3_emu_bank.sv
// ddr3_emu_bank: burst-wide RAM, one 128-bit row per 8 words, per-lane write enables, registered read.
module ddr3_emu_bank
    import ddr3_emu_pkg::*;
#(
    parameter int ROW_AW = 9
) (
    input  logic                          clk,
    input  logic [BURST_WORDS-1:0]        we_i,
    input  logic [ROW_AW-1:0]             waddr_i,
    input  logic [BURST_WORDS*WORD_W-1:0] wdata_i,
    input  logic [ROW_AW-1:0]             raddr_i,
    output logic [BURST_WORDS*WORD_W-1:0] rdata_o
);
    logic [BURST_WORDS*WORD_W-1:0] mem_q [2**ROW_AW];
    logic [BURST_WORDS*WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int l = 0; l < BURST_WORDS; l++)
            if (we_i[l]) mem_q[waddr_i][l*WORD_W +: WORD_W] <= wdata_i[l*WORD_W +: WORD_W];
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ddr3_emu_responder.sv
// ddr3_emu_responder: BRAM-backed stand-in for the ddr3_controller user port with emulated init/latency/refresh.
// Optional refresh-interval watchdog enabled by defining DDR3_EMU_REFRESH_CHECK_EN.
module ddr3_emu_responder
    import ddr3_emu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 26,
    parameter int MEM_AW      = 12,
    parameter int INIT_CYCLES = 64,
    parameter int WR_LATENCY  = 6,
    parameter int RD_LATENCY  = 10,
    parameter int REF_CYCLES  = 20,
    parameter int REFRESH_MAX = 1600
) (
    input logic                 pclk,
    input logic                 reset,
    ddr3_emu_responder_if.slave bus
);
    localparam int M1      = (INIT_CYCLES > WR_LATENCY) ? INIT_CYCLES : WR_LATENCY;
    localparam int M2      = (RD_LATENCY > REF_CYCLES) ? RD_LATENCY : REF_CYCLES;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int ROW_AW  = MEM_AW - 3;

    state_e                        state_q;
    logic [CW-1:0]                 cnt_q;
    logic [CW-1:0]                 lim;
    logic [MEM_AW-1:0]             addr_q;
    logic                          busy_q;
    logic                          ready_q;
    logic                          done_q;
    logic                          err_q;
    logic [WORD_W-1:0]             dout_q;
    logic [BURST_WORDS*WORD_W-1:0] dout128_q;
    logic [BURST_WORDS*WORD_W-1:0] row_rd;
    logic [BURST_WORDS-1:0]        we;
    logic                          idle;
    logic                          any_cmd;
    logic                          unused_ok;
    cmd_e                          cmd;

    assign idle      = state_q == S_IDLE;
    assign any_cmd   = bus.rd | bus.wr | bus.refresh;
    assign cmd       = pick_cmd(bus.rd, bus.wr, bus.refresh);
    assign we        = (idle && cmd == CMD_WR) ? BURST_WORDS'(1) << bus.addr[2:0] : '0;
    assign unused_ok = ^bus.addr[ADDR_WIDTH-1:MEM_AW];
    assign lim = (state_q == S_INIT)  ? CW'(INIT_CYCLES - 1) :
                 (state_q == S_WRITE) ? CW'(WR_LATENCY - 1)  :
                 (state_q == S_READ)  ? CW'(RD_LATENCY - 1)  : CW'(REF_CYCLES - 1);

    // Write lands in the acceptance cycle; the read row tracks the latched address.
    ddr3_emu_bank #(.ROW_AW(ROW_AW)) u_bank (
        .clk     (pclk),
        .we_i    (we),
        .waddr_i (bus.addr[MEM_AW-1:3]),
        .wdata_i ({BURST_WORDS{bus.din}}),
        .raddr_i (addr_q[MEM_AW-1:3]),
        .rdata_o (row_rd)
    );

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= '0;
            dout128_q <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= idle ? multi_cmd(bus.rd, bus.wr, bus.refresh) : any_cmd;
            if (idle) begin
                if (cmd != CMD_NONE) begin
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                    addr_q  <= bus.addr[MEM_AW-1:0];
                    state_q <= (cmd == CMD_REF) ? S_REFRESH : (cmd == CMD_WR) ? S_WRITE : S_READ;
                end
            end else if (cnt_q == lim) begin
                busy_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= S_IDLE;
                if (state_q == S_INIT) done_q <= 1'b1;
                if (state_q == S_READ) begin
                    ready_q   <= 1'b1;
                    dout_q    <= row_rd[lane_lsb(addr_q[2:0]) +: WORD_W];
                    dout128_q <= row_rd;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef DDR3_EMU_REFRESH_CHECK_EN
    localparam int RW = $clog2(REFRESH_MAX) + 1;

    logic [RW-1:0] ref_cnt_q;
    logic [RW-1:0] ref_cnt_d;
    logic          miss_q;

    always_comb begin
        ref_cnt_d = (idle && cmd == CMD_REF) ? '0 :
                    (done_q && ref_cnt_q != RW'(REFRESH_MAX)) ? ref_cnt_q + 1'b1 : ref_cnt_q;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            ref_cnt_q <= '0;
            miss_q    <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            miss_q    <= miss_q | (ref_cnt_d == RW'(REFRESH_MAX));
        end
    end

    assign bus.refresh_miss = miss_q;
`else
    assign bus.refresh_miss = 1'b0;
`endif

    assign bus.busy             = busy_q;
    assign bus.data_ready       = ready_q;
    assign bus.dout             = dout_q;
    assign bus.dout128          = dout128_q;
    assign bus.write_level_done = done_q;
    assign bus.read_calib_done  = done_q;
    assign bus.cmd_error        = err_q;
endmodule
